// File: rtl/rmw_pkg.sv
// Shared types and default sizes for the round-robin read-modify-write arbiter.
package rmw_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The request vector is doubled so one plain priority search covers the wrap.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] dbl;

    // Lower copy keeps only requesters at or above ptr; the upper copy is the wrap.
    always_comb begin
        dbl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            dbl[i]         = req[i] && (i >= int'(ptr));
            dbl[i + N_REQ] = req[i];
        end
    end

    always_comb begin
        winner = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                winner = (i >= N_REQ) ? PTR_W'(i - N_REQ) : PTR_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rmw_arbiter.sv
// Round-robin arbiter and sequencer sharing one read-modify-write mask datapath
// between N_REQ requesters: load+mask clear, sel shift cycles, write, done.
module rmw_arbiter
    import rmw_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEL_W-1:0] req_sel,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   load,
    output logic                   rst_mask,
    output logic [SEL_W-1:0]       sel_out,
    output logic                   shift,
    output logic                   wr
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: req[i] is a level held until its one-cycle done[i] pulse.
    // req/req_sel are captured only in IDLE; later changes are ignored.

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] win_sel;
    logic             any_req;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_sel = req_sel[int'(winner)*SEL_W +: SEL_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = (cnt != '0) ? SHIFT : WRITE;
            SHIFT:   if (cnt == SEL_W'(1)) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            owner   <= '0;
            sel_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        cnt     <= win_sel;
                        sel_out <= win_sel;
                    end
                end
                SHIFT:   cnt <= cnt - 1'b1;
                // Advancing past the owner puts a re-requesting owner behind the others.
                DONE:    ptr <= (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        grant    = '0;
        done     = '0;
        busy     = 1'b0;
        load     = 1'b0;
        rst_mask = 1'b0;
        shift    = 1'b0;
        wr       = 1'b0;
        if (state != IDLE) begin
            busy         = 1'b1;
            grant[owner] = 1'b1;
        end
        case (state)
            LOAD: begin
                load     = 1'b1;
                rst_mask = 1'b1;
            end
            SHIFT:   shift       = 1'b1;
            WRITE:   wr          = 1'b1;
            DONE:    done[owner] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rmw_arbiter.sv
// Bench for rmw_arbiter: cycle table, directed multi-cycle sequences and a
// random phase, all checked against an operation-level reference model.
module tb_rmw_arbiter;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int W  = 2*N + 5 + SW + 1;

    typedef struct {
        logic            rst;
        logic [N-1:0]    req;
        logic [N*SW-1:0] sel;
        logic [W-1:0]    exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*SW-1:0] req_sel;
    logic [N-1:0]    grant, done;
    logic            busy, load, rst_mask, shift, wr;
    logic [SW-1:0]   sel_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [W-1:0] exp_q[$];
    logic         cur_idle = 1'b1;
    int           mptr     = 0;

    logic [N-1:0] load_log[$];
    int           load_cyc[$];
    logic [N-1:0] done_log[$];
    int           done_cyc[$];
    int           shift_cnt = 0;

    vec_t tbl[$];

    rmw_arbiter #(.N_REQ(N), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_sel  (req_sel),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .load     (load),
        .rst_mask (rst_mask),
        .sel_out  (sel_out),
        .shift    (shift),
        .wr       (wr)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Bundle layout: {sel_valid, grant, done, busy, load, rst_mask, shift, wr, sel_out}
    function automatic logic [W-1:0] pack(logic sv, logic [N-1:0] g, logic [N-1:0] d,
                                          logic b, logic l, logic rm, logic sh, logic w,
                                          logic [SW-1:0] s);
        return {sv, g, d, b, l, rm, sh, w, s};
    endfunction

    function automatic logic [W-1:0] actual();
        return {1'b1, grant, done, busy, load, rst_mask, shift, wr, sel_out};
    endfunction

    function automatic vec_t mk(logic r, logic [N-1:0] q, logic [N*SW-1:0] s, logic [W-1:0] e);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.sel = s;
        v.exp = e;
        return v;
    endfunction

    // scoreboard compare; sel_out is only meaningful while an operation runs or after reset
    task automatic check(string name, logic [W-1:0] e);
        logic [W-1:0] a;
        logic [W-1:0] m;
        a = actual();
        m = e[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b0, {(W-1-SW){1'b1}}, {SW{1'b0}}};
        vectors++;
        if ((a & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h (mask %h)", name, cyc, a & m, e & m, m);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // reference model: one whole operation is queued as per-cycle expectations
    task automatic push_op();
        int            w;
        logic [SW-1:0] s;
        logic [N-1:0]  g;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
        end
        s = req_sel[w*SW +: SW];
        g = N'(1) << w;
        exp_q.push_back(pack(1'b1, g, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, s));
        for (int k = 0; k < int'(s); k++)
            exp_q.push_back(pack(1'b1, g, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s));
        exp_q.push_back(pack(1'b1, g, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, s));
        exp_q.push_back(pack(1'b1, g, g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s));
        mptr = (w + 1) % N;
    endtask

    // driver: one clock with the current inputs, then compare against the model
    task automatic cycle(string name);
        logic [W-1:0] e;
        logic         was_rst;
        was_rst = rst;
        if (rst) begin
            exp_q.delete();
            mptr = 0;
        end else if (cur_idle && req != '0) begin
            push_op();
        end
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            e = pack(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            cur_idle = 1'b1;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = pack(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            cur_idle = 1'b1;
        end
        check(name, e);
        if (load) begin
            load_log.push_back(grant);
            load_cyc.push_back(cyc);
        end
        if (done != '0) begin
            done_log.push_back(done);
            done_cyc.push_back(cyc);
        end
        if (shift) shift_cnt++;
    endtask

    task automatic clear_logs();
        load_log.delete();
        load_cyc.delete();
        done_log.delete();
        done_cyc.delete();
        shift_cnt = 0;
    endtask

    task automatic drain();
        req = '0;
        for (int i = 0; i < 64 && !cur_idle; i++) cycle("drain");
    endtask

    initial begin
        logic [W-1:0] own0_ld, own0_sh, own0_wr, own0_dn, own2_ld, own2_wr, own2_dn, idle_v;
        own0_ld = pack(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        own0_sh = pack(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        own0_wr = pack(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        own0_dn = pack(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        own2_ld = pack(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        own2_wr = pack(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        own2_dn = pack(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle_v  = pack(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // requester 0, sel=3: load t1, shift t2..t4, wr t5, done t6, idle t7
        tbl.push_back(mk(1'b1, 4'b0000, 12'h000, pack(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0)));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_ld));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_sh));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_sh));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_sh));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_wr));
        tbl.push_back(mk(1'b0, 4'b0001, 12'h003, own0_dn));
        tbl.push_back(mk(1'b0, 4'b0000, 12'h003, idle_v));
        tbl.push_back(mk(1'b0, 4'b0000, 12'h003, idle_v));
        // requester 2, sel=0 (others nonzero): load, write, done at t+3, no shift
        tbl.push_back(mk(1'b0, 4'b0100, 12'hE2E, own2_ld));
        tbl.push_back(mk(1'b0, 4'b0100, 12'hE2E, own2_wr));
        tbl.push_back(mk(1'b0, 4'b0100, 12'hE2E, own2_dn));
        tbl.push_back(mk(1'b0, 4'b0000, 12'hE2E, idle_v));

        rst = 1'b1;
        req = '0;
        req_sel = '0;
        foreach (tbl[i]) begin
            rst     = tbl[i].rst;
            req     = tbl[i].req;
            req_sel = tbl[i].sel;
            cycle($sformatf("model_tbl%0d", i));
            check($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // all four requesting with sel=1 after reset: grants 0,1,2,3,0 every 5 cycles
        rst = 1'b1;
        cycle("rr_reset");
        rst = 1'b0;
        clear_logs();
        req = 4'b1111;
        req_sel = 12'h249;
        repeat (25) cycle("rr");
        check_val("rr_loads", load_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("rr_grant%0d", k), int'(load_log[k]), 1 << (k % N));
            if (k > 0) check_val($sformatf("rr_gap%0d", k), load_cyc[k] - load_cyc[k-1], 5);
        end
        drain();

        // reset during the second shift cycle of a sel=5 operation
        clear_logs();
        req = 4'b0010;
        req_sel = 12'h028;
        repeat (3) cycle("abort_run");
        rst = 1'b1;
        cycle("abort_rst");
        check("abort_zero", pack(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        rst = 1'b0;
        req = 4'b1011;
        req_sel = 12'h252;
        cycle("abort_regrant");
        check_val("abort_winner", int'(grant), 1);
        check_val("abort_no_done", done_log.size(), 0);
        drain();

        // owner drops req and changes its sel mid-shift
        clear_logs();
        req = 4'b0110;
        req_sel = 12'h0A0;
        repeat (2) cycle("drop_run");
        req = 4'b0100;
        req_sel = 12'h0B8;
        repeat (7) cycle("drop_run");
        check_val("drop_shifts", shift_cnt, 4);
        check_val("drop_done", int'(done_log[0]), 2);
        check_val("drop_next", int'(load_log[load_log.size()-1]), 4);
        drain();

        // sel=7 on requester 1 while requester 3 waits
        clear_logs();
        req = 4'b0010;
        req_sel = 12'h438;
        cycle("max_run");
        req = 4'b1010;
        repeat (11) cycle("max_run");
        check_val("max_shifts", shift_cnt, 7);
        check_val("max_done", int'(done_log[0]), 2);
        check_val("max_next", int'(load_log[load_log.size()-1]), 8);
        check_val("max_gap", load_cyc[load_cyc.size()-1] - done_cyc[0], 2);
        drain();

        // random requests, selects and occasional resets against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_sel = (N*SW)'($urandom);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
